// File: rtl/ifetch_line_prefetcher.sv
// Instruction-fetch line prefetcher: requests 16-byte aligned lines, one outstanding,
// and feeds them to the fetch FIFO, flushing it with the first line after a redirect.
module ifetch_line_prefetcher #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    LINE_WIDTH = 128,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_redirect,
   input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
   input  logic                  i_fifo_full,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_ready,
   input  logic                  i_mem_valid,
   input  logic [LINE_WIDTH-1:0] i_mem_rdata,
   output logic [LINE_WIDTH-1:0] o_fifo_wdata,
   output logic                  o_fifo_wen,
   output logic                  o_fifo_flush,
   output logic [1:0]            o_fifo_word_sel,
   output logic                  o_redirect_busy
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_PUSH} state_t;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(4'hF);
   localparam logic [ADDR_WIDTH-1:0] LINE_BYTES = ADDR_WIDTH'(16);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
   logic [LINE_WIDTH-1:0] line_buf_q, line_buf_d;
   logic                  flush_pending_q, flush_pending_d;
   logic [1:0]            word_sel_q, word_sel_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q         <= S_REQ;
         line_addr_q     <= RESET_PC & LINE_MASK;
         line_buf_q      <= '0;
         flush_pending_q <= 1'b1;
         word_sel_q      <= RESET_PC[3:2];
      end else begin
         state_q         <= state_d;
         line_addr_q     <= line_addr_d;
         line_buf_q      <= line_buf_d;
         flush_pending_q <= flush_pending_d;
         word_sel_q      <= word_sel_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      line_addr_d     = line_addr_q;
      line_buf_d      = line_buf_q;
      flush_pending_d = flush_pending_q;
      word_sel_d      = word_sel_q;
      if (i_redirect) begin
         line_addr_d     = i_redirect_pc & LINE_MASK;
         word_sel_d      = i_redirect_pc[3:2];
         flush_pending_d = 1'b1;
         // an accepted-but-unanswered request must be drained before the target is fetched;
         // a response landing together with the redirect completes that drain
         unique case (state_q)
            S_REQ:   state_d = i_mem_ready ? S_DRAIN : S_REQ;
            S_WAIT:  state_d = i_mem_valid ? S_REQ : S_DRAIN;
            S_DRAIN: state_d = i_mem_valid ? S_REQ : S_DRAIN;
            S_PUSH:  state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (i_mem_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (i_mem_valid) begin
                  line_buf_d = i_mem_rdata;
                  state_d    = S_PUSH;
               end
            end
            S_DRAIN: begin
               if (i_mem_valid) state_d = S_REQ;
            end
            S_PUSH: begin
               if (flush_pending_q) begin
                  flush_pending_d = 1'b0;
                  line_addr_d     = line_addr_q + LINE_BYTES;
                  state_d         = S_REQ;
               end else if (!i_fifo_full) begin
                  line_addr_d = line_addr_q + LINE_BYTES;
                  state_d     = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   // the flush line is loaded as slot 0 regardless of FIFO occupancy
   always_comb begin
      o_mem_req    = (state_q == S_REQ);
      o_fifo_flush = (state_q == S_PUSH) && flush_pending_q && !i_redirect;
      o_fifo_wen   = (state_q == S_PUSH) && !flush_pending_q && !i_fifo_full && !i_redirect;
   end

   assign o_mem_addr      = line_addr_q;
   assign o_fifo_wdata    = line_buf_q;
   assign o_fifo_word_sel = word_sel_q;
   assign o_redirect_busy = flush_pending_q;

endmodule

// File: tb/tb_ifetch_line_prefetcher.sv
// Bench for ifetch_line_prefetcher: random memory/FIFO/redirect traffic checked cycle by
// cycle against a transaction-level model of requests, responses and deliveries.
module tb_ifetch_line_prefetcher;
   localparam logic [31:0] RPC = 32'h0040_0008;

   logic         i_clk = 1'b0;
   logic         i_rst, i_redirect, i_fifo_full, i_mem_ready, i_mem_valid;
   logic [31:0]  i_redirect_pc;
   logic [127:0] i_mem_rdata;
   logic         o_mem_req, o_fifo_wen, o_fifo_flush, o_redirect_busy;
   logic [31:0]  o_mem_addr;
   logic [127:0] o_fifo_wdata;
   logic [1:0]   o_fifo_word_sel;

   always #5 i_clk = ~i_clk;

   ifetch_line_prefetcher #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .RESET_PC(RPC)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .i_fifo_full(i_fifo_full), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
      .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata),
      .o_fifo_wdata(o_fifo_wdata), .o_fifo_wen(o_fifo_wen), .o_fifo_flush(o_fifo_flush),
      .o_fifo_word_sel(o_fifo_word_sel), .o_redirect_busy(o_redirect_busy));

   int checks = 0, errors = 0;

   // model: next line to request, pending flush, held line, outstanding request
   logic [31:0]  m_exp, m_oaddr;
   logic [1:0]   m_ws;
   bit           m_pend, m_have, m_out, m_stale;
   logic [127:0] m_line;
   int           m_lat;

   int p_redir = 0, p_ready = 100, p_full = 0, p_spur = 0, min_lat = 0, max_lat = 0;
   bit f_redir = 0;
   logic [31:0] f_pc = '0;
   bit wrap_dlv = 0, wrap_ok = 0;

   function automatic logic [127:0] line_of(logic [31:0] a);
      return {~a, a ^ 32'h5a5a_0000, a + 32'h1111, a};
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_exp = RPC & ~32'hF; m_ws = RPC[3:2]; m_pend = 1;
      m_have = 0; m_out = 0; m_stale = 0; m_lat = 0; m_line = '0; m_oaddr = '0;
   endtask

   // called at a negedge: drive one cycle, check outputs, advance model past the posedge
   task automatic cyc();
      bit redir, rdy, full, resp, spur, exp_req, exp_fl, exp_wen, acc, dlv;
      logic [31:0] pc;
      redir = f_redir || ($urandom_range(99) < p_redir);
      pc    = f_redir ? f_pc : $urandom;
      rdy   = $urandom_range(99) < p_ready;
      full  = $urandom_range(99) < p_full;
      resp  = m_out && (m_lat == 0);
      spur  = !m_out && ($urandom_range(99) < p_spur);
      i_redirect = redir; i_redirect_pc = pc; i_mem_ready = rdy; i_fifo_full = full;
      i_mem_valid = resp || spur;
      i_mem_rdata = resp ? line_of(m_oaddr) : {$urandom, $urandom, $urandom, $urandom};
      #1;
      exp_req = !m_out && !m_have;
      exp_fl  = m_have && !redir && m_pend;
      exp_wen = m_have && !redir && !m_pend && !full;
      chk("mem_req", o_mem_req, exp_req);
      if (exp_req) chk("mem_addr", o_mem_addr, m_exp);
      chk("fifo_flush", o_fifo_flush, exp_fl);
      chk("fifo_wen", o_fifo_wen, exp_wen);
      chk("busy", o_redirect_busy, m_pend);
      chk("word_sel", o_fifo_word_sel, m_ws);
      if (exp_fl || exp_wen) chk("fifo_wdata", o_fifo_wdata, m_line);
      acc = exp_req && rdy;
      dlv = exp_fl || exp_wen;
      if (resp) begin
         m_out = 0;
         if (!m_stale && !redir) begin m_have = 1; m_line = line_of(m_oaddr); end
      end else if (m_out) m_lat--;
      if (acc) begin
         if (wrap_dlv && o_mem_addr == 32'h0) wrap_ok = 1;
         m_out = 1; m_stale = 0; m_oaddr = m_exp; m_lat = $urandom_range(max_lat, min_lat);
      end
      if (dlv) begin
         if (m_exp == 32'hFFFF_FFF0) wrap_dlv = 1;
         m_have = 0; m_pend = 0; m_exp += 32'd16;
      end
      if (redir) begin
         m_have = 0;
         if (m_out) m_stale = 1;
         m_exp = pc & ~32'hF; m_ws = pc[3:2]; m_pend = 1;
      end
      @(negedge i_clk);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // memory shares reset and forgets anything in flight
   task automatic do_reset(bit redir);
      i_rst = 1; i_redirect = redir; i_redirect_pc = 32'h0000_BEE4;
      i_mem_valid = 0; i_mem_ready = 1; i_fifo_full = 0;
      @(negedge i_clk); @(negedge i_clk);
      i_rst = 0; i_redirect = 0;
      model_reset();
      #1;
      chk("rst_mem_req", o_mem_req, 1'b1);
      chk("rst_mem_addr", o_mem_addr, 32'h0040_0000);
      chk("rst_wen", o_fifo_wen, 1'b0);
      chk("rst_flush", o_fifo_flush, 1'b0);
      chk("rst_wdata", o_fifo_wdata, 128'h0);
      chk("rst_word_sel", o_fifo_word_sel, 2'd2);
      chk("rst_busy", o_redirect_busy, 1'b1);
      #1;
   endtask

   task automatic wait_model(int kind);
      int n = 0;
      while (n < 100 && !((kind == 0) ? (m_out && !m_stale && m_lat > 0) : m_have)) begin
         cyc(); n++;
      end
      chk("reach_condition", n < 100, 1'b1);
   endtask

   initial begin
      i_rst = 1; i_redirect = 0; i_redirect_pc = '0; i_fifo_full = 0;
      i_mem_ready = 1; i_mem_valid = 0; i_mem_rdata = '0;
      do_reset(1);

      // zero-wait memory: request at 0, flush at 2, next request at 3
      run(20);
      // FIFO back-pressure during PUSH
      p_full = 60; run(60);
      // random ready, latency and stray valids
      p_full = 20; p_ready = 50; max_lat = 4; p_spur = 20; run(200);

      // redirect to 0x1234 while waiting on a latency-5 response
      p_full = 0; p_ready = 100; min_lat = 5; max_lat = 5; p_spur = 0;
      wait_model(0);
      f_redir = 1; f_pc = 32'h0000_1234; cyc(); f_redir = 0;
      chk("wait_redir_word_sel", o_fifo_word_sel, 2'd1);
      chk("wait_redir_busy", o_redirect_busy, 1'b1);
      run(30);

      // redirect in the same cycle as a PUSH
      min_lat = 0; max_lat = 2; p_full = 50;
      wait_model(1);
      f_redir = 1; f_pc = 32'h0002_0008; cyc(); f_redir = 0;
      chk("push_redir_busy", o_redirect_busy, 1'b1);
      run(20);

      // address wrap
      p_full = 0; max_lat = 0; wrap_dlv = 0; wrap_ok = 0;
      f_redir = 1; f_pc = 32'hFFFF_FFF4; cyc(); f_redir = 0;
      run(12);
      chk("wrap_to_zero", wrap_ok, 1'b1);

      // redirects everywhere
      p_redir = 15; p_full = 30; p_ready = 60; max_lat = 4; p_spur = 10; run(1000);

      // reset during WAIT
      p_redir = 0; min_lat = 4; max_lat = 4; p_spur = 0; p_full = 0; p_ready = 100;
      wait_model(0);
      do_reset(0);
      min_lat = 0; max_lat = 3; p_redir = 10; p_full = 30; p_ready = 70; run(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
